// File: rtl/uart_banner_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_banner_engine: UART command decoder, BCD banner store and circular  |
// | seven-segment scroller.                                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_banner_engine #(
  parameter int NUM_DIGITS = 6,
  parameter int MAX_LEN    = 16,
  parameter int GAP        = 2,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_valid_i,
  output logic [4*NUM_DIGITS-1:0]      digits_o,
  output logic                         write_mode_o,
  output logic                         running_o,
  output logic                         dir_right_o,
  output logic [$clog2(MAX_LEN+1)-1:0] banner_len_o,
  output logic                         overflow_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int SEQ_W = $clog2(MAX_LEN + GAP + 1);
  localparam int ADR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PRE_W = $clog2(SCROLL_DIV);

  localparam logic [LEN_W-1:0] C_FULL     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] C_ONE_L    = LEN_W'(1);
  localparam logic [SEQ_W-1:0] C_GAP      = SEQ_W'(GAP);
  localparam logic [SEQ_W-1:0] C_ONE_S    = SEQ_W'(1);
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(SCROLL_DIV - 1);
  localparam logic [PRE_W-1:0] C_ONE_P    = PRE_W'(1);
  localparam logic [3:0]       C_BLANK    = 4'hF;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        fill_q, fill_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    ovf_q, ovf_d;
  logic                    run_q, run_d;
  logic                    dir_q, dir_d;
  logic [SEQ_W-1:0]        off_q, off_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [3:0]              buf_q [MAX_LEN];

  logic                    wr_en;
  logic [3:0]              wr_nib;
  logic                    is_digit, is_space;
  logic [SEQ_W-1:0]        v_last;
  logic [SEQ_W-1:0]        lim;
  logic [SEQ_W-1:0]        lim_last;
  logic [SEQ_W-1:0]        idx;

  assign is_digit = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
  assign is_space = (rx_data_i == 8'h20);
  assign v_last   = SEQ_W'(len_q) + C_GAP - C_ONE_S;

  // Commands resolve before the prescaler so that p/l/r affect a coincident step.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    run_d   = run_q;
    dir_d   = dir_q;
    off_d   = off_q;
    presc_d = presc_q;
    wr_en   = 1'b0;
    wr_nib  = is_space ? C_BLANK : rx_data_i[3:0];
    if (rx_valid_i) begin
      if (state_q == ST_WRITE) begin
        if (is_digit || is_space) begin
          if (fill_q == C_FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            fill_d = fill_q + C_ONE_L;
          end
        end else if (rx_data_i == 8'h0D) begin
          state_d = ST_SHOW;
          len_d   = fill_q;
          off_d   = '0;
          presc_d = '0;
        end else if (rx_data_i == 8'h77) begin
          fill_d = '0;
        end
      end else begin
        case (rx_data_i)
          8'h77: begin
            state_d = ST_WRITE;
            fill_d  = '0;
            ovf_d   = 1'b0;
            run_d   = 1'b0;
          end
          8'h73:   run_d = 1'b1;
          8'h70:   run_d = 1'b0;
          8'h6C:   dir_d = 1'b0;
          8'h72:   dir_d = 1'b1;
          default: ;
        endcase
      end
    end
    if (run_d) begin
      if (presc_q == C_PRE_LAST) begin
        presc_d = '0;
        if (dir_d) off_d = (off_q == '0) ? v_last : off_q - C_ONE_S;
        else       off_d = (off_q == v_last) ? '0 : off_q + C_ONE_S;
      end else begin
        presc_d = presc_q + C_ONE_P;
      end
    end
  end

  // Write mode shows the partial entry from offset 0 with its own period.
  always_comb begin
    lim      = (state_q == ST_WRITE) ? SEQ_W'(fill_q) : SEQ_W'(len_q);
    lim_last = lim + C_GAP - C_ONE_S;
    idx      = (state_q == ST_WRITE) ? '0 : off_q;
    digits_d = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      digits_d[4*(NUM_DIGITS-1-j) +: 4] = (idx < lim) ? buf_q[idx[ADR_W-1:0]] : C_BLANK;
      idx = (idx == lim_last) ? '0 : idx + C_ONE_S;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) buf_q[fill_q[ADR_W-1:0]] <= wr_nib;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_SHOW;
      fill_q   <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      run_q    <= 1'b0;
      dir_q    <= 1'b0;
      off_q    <= '0;
      presc_q  <= '0;
      digits_q <= '1;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      off_q    <= off_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
    end
  end

  assign digits_o     = digits_q;
  assign write_mode_o = (state_q == ST_WRITE);
  assign running_o    = run_q;
  assign dir_right_o  = dir_q;
  assign banner_len_o = len_q;
  assign overflow_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_banner_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_banner_engine: directed stimulus with a cycle-tagged scoreboard. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_banner_engine;
  localparam int ND = 6;
  localparam int ML = 16;
  localparam int G  = 2;
  localparam int SD = 4;
  localparam int LW = $clog2(ML + 1);

  localparam int S_DIG = 0;
  localparam int S_WM  = 1;
  localparam int S_RUN = 2;
  localparam int S_DIR = 3;
  localparam int S_LEN = 4;
  localparam int S_OVF = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [4*ND-1:0] digits;
  logic          wm, run, dir, ovf;
  logic [LW-1:0] blen;

  always #5 clk = ~clk;

  uart_banner_engine #(
    .NUM_DIGITS(ND), .MAX_LEN(ML), .GAP(G), .SCROLL_DIV(SD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .digits_o(digits), .write_mode_o(wm), .running_o(run), .dir_right_o(dir),
    .banner_len_o(blen), .overflow_o(ovf)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] act;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_DIG:   return 32'(digits);
      S_WM:    return {31'b0, wm};
      S_RUN:   return {31'b0, run};
      S_DIR:   return {31'b0, dir};
      S_LEN:   return 32'(blen);
      S_OVF:   return {31'b0, ovf};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: every expectation is tagged with the cycle on which it must hold.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      cur = q.pop_front();
      act = actual(cur.sel);
      total++;
      if (cur.due < cyc) begin
        bad++;
        $display("FAIL %s: check due at cycle %0d not reached until %0d", cur.name, cur.due, cyc);
      end else if (act !== cur.exp) begin
        bad++;
        $display("FAIL %s: cycle %0d got %h expected %h", cur.name, cyc, act, cur.exp);
      end
    end
  end

  task automatic expect_at(input string name, input int sel, input logic [31:0] v, input int d);
    exp_t e;
    int   i;
    e.due  = cyc + d;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    i = 0;
    while (i < q.size() && q[i].due <= e.due) i++;
    q.insert(i, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_reset_state(input string tag, input int d);
    expect_at({tag, "_digits"}, S_DIG, 32'hFFFFFF, d);
    expect_at({tag, "_wm"},     S_WM,  32'd0, d);
    expect_at({tag, "_run"},    S_RUN, 32'd0, d);
    expect_at({tag, "_dir"},    S_DIR, 32'd0, d);
    expect_at({tag, "_len"},    S_LEN, 32'd0, d);
    expect_at({tag, "_ovf"},    S_OVF, 32'd0, d);
  endtask

  initial begin
    // Reset, checked both while held and after release.
    rst_n = 1'b0;
    idle(3);
    expect_reset_state("rst_held", 1);
    idle(1);
    rst_n = 1'b1;
    expect_reset_state("rst_rel", 1);
    idle(2);

    // Commit "123456" and scroll left through a full period of 8 steps.
    send("w");
    send_str("123456");
    send(8'h0D);
    expect_at("commit_digits", S_DIG, 32'h123456, 1);
    expect_at("commit_len",    S_LEN, 32'd6, 1);
    expect_at("commit_wm",     S_WM,  32'd0, 1);
    idle(2);
    send("s");
    expect_at("s_run",      S_RUN, 32'd1, 1);
    expect_at("pre_step",   S_DIG, 32'h123456, 3);
    expect_at("left_step1", S_DIG, 32'h23456F, 4);
    expect_at("left_step2", S_DIG, 32'h3456FF, 8);
    expect_at("left_step6", S_DIG, 32'hFF1234, 24);
    expect_at("left_step7", S_DIG, 32'hF12345, 28);
    expect_at("left_wrap",  S_DIG, 32'h123456, 32);
    idle(32);
    send("p");
    expect_at("p_run", S_RUN, 32'd0, 1);
    idle(2);

    // Recommit, scroll right, pause mid-count, resume, and coincident commands.
    send("w");
    send_str("123456");
    send(8'h0D);
    idle(1);
    send("r");
    send("s");
    expect_at("r_dir",       S_DIR, 32'd1, 1);
    expect_at("r_run",       S_RUN, 32'd1, 1);
    expect_at("r_pre_step",  S_DIG, 32'h123456, 3);
    expect_at("right_step1", S_DIG, 32'hF12345, 4);
    expect_at("right_step2", S_DIG, 32'hFF1234, 8);
    idle(9);
    send("p");
    expect_at("pause_run",   S_RUN, 32'd0, 1);
    expect_at("pause_hold1", S_DIG, 32'hFF1234, 1);
    expect_at("pause_hold2", S_DIG, 32'hFF1234, 100);
    idle(100);
    send("s");
    expect_at("resume_before", S_DIG, 32'hFF1234, 1);
    expect_at("resume_step",   S_DIG, 32'h6FF123, 2);
    idle(4);
    send("l");
    expect_at("l_coinc_old", S_DIG, 32'h6FF123, 0 + 1 - 1 + 0 == 0 ? 0 : 0);
    expect_at("l_coinc_dir", S_DIR, 32'd0, 1);
    expect_at("l_coinc_new", S_DIG, 32'hFF1234, 1);
    idle(3);
    send("p");
    expect_at("p_coinc_run",   S_RUN, 32'd0, 1);
    expect_at("p_coinc_hold1", S_DIG, 32'hFF1234, 1);
    expect_at("p_coinc_hold2", S_DIG, 32'hFF1234, 5);
    idle(5);

    // Entry display, overflow boundary and overflow clear.
    send("w");
    expect_at("w_wm",    S_WM,  32'd1, 1);
    expect_at("w_blank", S_DIG, 32'hFFFFFF, 1);
    idle(1);
    send_str("12");
    expect_at("partial_view", S_DIG, 32'h12FF12, 1);
    idle(1);
    send("s");
    expect_at("s_ignored_in_write", S_RUN, 32'd0, 1);
    idle(1);
    send_str("34567890123456");
    expect_at("full_no_ovf",  S_OVF, 32'd0, 1);
    expect_at("len_uncommit", S_LEN, 32'd6, 1);
    idle(1);
    send_str("78");
    expect_at("drop_ovf",  S_OVF, 32'd1, 1);
    expect_at("full_view", S_DIG, 32'h123456, 1);
    idle(1);
    send(8'h0D);
    expect_at("full_len",    S_LEN, 32'd16, 1);
    expect_at("full_wm",     S_WM,  32'd0, 1);
    expect_at("ovf_sticky",  S_OVF, 32'd1, 1);
    expect_at("full_digits", S_DIG, 32'h123456, 1);
    idle(1);
    send("w");
    expect_at("ovf_clear", S_OVF, 32'd0, 1);
    expect_at("rew_wm",    S_WM,  32'd1, 1);
    idle(1);
    send(8'h0D);
    expect_at("empty_len", S_LEN, 32'd0, 1);
    idle(2);

    // Reset in the middle of an entry, then scroll an empty banner.
    send("w");
    send_str("12");
    rst_n = 1'b0;
    expect_reset_state("mid_rst", 1);
    idle(2);
    rst_n = 1'b1;
    expect_reset_state("post_rst", 1);
    idle(1);
    send("s");
    expect_at("empty_run",    S_RUN, 32'd1, 1);
    expect_at("empty_blank1", S_DIG, 32'hFFFFFF, 5);
    expect_at("empty_blank2", S_DIG, 32'hFFFFFF, 9);
    idle(10);

    begin
      int t;
      t = 0;
      while (q.size() > 0 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (q.size() > 0) begin
        $display("FAIL scoreboard_drain: %0d checks left, required 0", q.size());
        total += q.size();
        bad   += q.size();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
